hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Parametrised successor to the pipeline hazard detector of the 5-stage core. Detects load-to-use, branch-register and branch-flag RAW hazards, and drives per-stage write-enables and flushes. Adds registered stall/flush sequencing: multi-cycle taken-branch flush, I/D-cache miss freeze, and saturating performance counters. Sits beside the ID stage; outputs feed the PC, IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
REG_W, 4, register-index width; index 0 is the hard-wired zero register.
FLAG_W, 3, flag-enable vector width (Z/V/N).
FLUSH_CYCLES, 1, cycles if_id_flush is held after a taken branch (1..7).
CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
id_ex_mem_read  in  1  load in EX
id_ex_reg_write  in  1  EX instruction writes rd
ex_mem_reg_write  in  1  MEM instruction writes rd
if_id_mem_write  in  1  decoding instruction is a store
if_id_rs, if_id_rt  in  REG_W  source registers of the ID instruction
id_ex_rd, ex_mem_rd  in  REG_W  destinations in EX and MEM
branch, branchr  in  1  ID instruction is B / BR
condition  in  3  branch condition code
id_ex_flag_en, ex_mem_flag_en  in  FLAG_W  flags written by EX / MEM instruction
br_taken  in  1  branch resolved taken in ID
icache_miss, dcache_miss  in  1  memory busy
pc_wen, if_id_wen, id_ex_wen, ex_mem_wen  out  1  pipeline-register write enables
id_ex_bubble  out  1  load NOP into ID/EX
if_id_flush  out  1  squash IF/ID contents
stall_cnt, flush_cnt  out  CNT_W  saturating event counters
state  out  2  FSM state, for debug

Behaviour:
- Reset: state=RUN, counters=0, flush down-counter=0. All wen=1, bubble=0, if_id_flush=0 in the cycle after rst.
- Hazard terms are combinational and only checked for rd!=0:
  - l2u = id_ex_mem_read & (rd==rs | (rd==rt & ~if_id_mem_write)).
  - br_rs = (branch|branchr) & RAW on rs against id_ex_rd (if id_ex_reg_write) or ex_mem_rd (if ex_mem_reg_write).
  - br_flag = (branch|branchr) & (needed & (id_ex_flag_en|ex_mem_flag_en)) != 0.
  - Needed-flag mask: 000/001 → Z; 010/100/101 → Z|N; 011 → N; 110 → V; 111 → none.
- haz = l2u | br_rs | br_flag. While haz in RUN: pc_wen=if_id_wen=0, id_ex_bubble=1, stall_cnt+1.
- FSM states RUN, DMISS, IMISS, FLUSH. Priority: dcache_miss > icache_miss > haz > br_taken.
  - DMISS (entered/held while dcache_miss): all four wen=0, bubble=0, no flush. Exit to RUN the cycle dcache_miss falls.
  - IMISS (icache_miss, no dcache_miss): pc_wen=if_id_wen=0, id_ex_bubble=1, downstream wen=1. Exit to RUN when icache_miss falls.
  - A miss arriving during FLUSH preempts it. The remaining flush count is preserved, and FLUSH resumes after the miss clears.
- Taken branch: br_taken & (branch|branchr) & ~haz in RUN → if_id_flush=1 that cycle. Load counter with FLUSH_CYCLES-1.
  - If the counter is nonzero, go to FLUSH. FLUSH holds if_id_flush=1, decrements each cycle, and returns to RUN at 0.
  - A new branch in FLUSH is ignored (it is squashed).
- br_taken while haz=1 is ignored: the branch is stalled, not resolved.
- Counters: stall_cnt +1 per cycle with any stall (haz, DMISS, IMISS). flush_cnt +1 per cycle with if_id_flush=1. Both saturate at all-ones, no wrap.
- rst mid-operation overrides everything on the next edge.

Decomposition:
- Package hazard_pkg:
  - FLAG_Z=2, FLAG_V=1, FLAG_N=0.
  - Condition code constants.
  - State encoding RUN=0, DMISS=1, IMISS=2, FLUSH=3.
  - Function cond_flag_mask(condition).
- One sub-module, sat_counter (width CNT_W, inc, clear), instantiated twice.

Test Plan:
1. LW R3 in EX (mem_read=1, id_ex_rd=3), ID rs=3 → one cycle pc_wen=0, if_id_wen=0, id_ex_bubble=1, stall_cnt=1. Same case with rt=3 and if_id_mem_write=1 → no stall.
2. id_ex_flag_en=3'b100 (Z), branch=1, condition=000 → stall. Same with condition=110 → no stall. condition=111 → never stalls.
3. FLUSH_CYCLES=3, br_taken=1, branch=1, no hazard → if_id_flush high exactly 3 cycles, state RUN→FLUSH→FLUSH→RUN, flush_cnt=3.
4. dcache_miss high for 4 cycles while icache_miss=1 and l2u=1 → all wen=0 for 4 cycles, state=DMISS. Then IMISS until icache_miss falls. stall_cnt counts every cycle.
5. CNT_W=4, stall 20 cycles → stall_cnt=15 and holds. Assert rst mid-FLUSH → next cycle state=RUN, counters=0, if_id_flush=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard control unit: flag bit positions, branch
// condition codes, FSM state encoding and the condition-to-flag lookup.
package hazard_pkg;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam logic [2:0] COND_EQ = 3'b000;
  localparam logic [2:0] COND_NE = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_UN = 3'b111;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DMISS = 2'd1;
  localparam logic [1:0] ST_IMISS = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // Flags a branch must see settled before it can resolve its condition.
  function automatic logic [2:0] cond_flag_mask(input logic [2:0] condition);
    logic [2:0] mask;
    mask = '0;
    case (condition)
      COND_EQ, COND_NE: mask[FLAG_Z] = 1'b1;
      COND_GT, COND_GE, COND_LE: begin
        mask[FLAG_Z] = 1'b1;
        mask[FLAG_N] = 1'b1;
      end
      COND_LT: mask[FLAG_N] = 1'b1;
      COND_OV: mask[FLAG_V] = 1'b1;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import hazard_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard detector with registered miss freeze, multi-cycle branch
// flush sequencing and saturating stall/flush counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_W        = 4,
  parameter int FLAG_W       = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_reg_write,
  input  logic              ex_mem_reg_write,
  input  logic              if_id_mem_write,
  input  logic [REG_W-1:0]  if_id_rs,
  input  logic [REG_W-1:0]  if_id_rt,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic [REG_W-1:0]  ex_mem_rd,
  input  logic              branch,
  input  logic              branchr,
  input  logic [2:0]        condition,
  input  logic [FLAG_W-1:0] id_ex_flag_en,
  input  logic [FLAG_W-1:0] ex_mem_flag_en,
  input  logic              br_taken,
  input  logic              icache_miss,
  input  logic              dcache_miss,
  output logic              pc_wen,
  output logic              if_id_wen,
  output logic              id_ex_wen,
  output logic              ex_mem_wen,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        state
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [2:0]        flush_rem;
  logic [FLAG_W-1:0] needed;
  logic              is_branch, l2u, br_rs, br_flag, haz;
  logic              any_miss, flushing, haz_stall, take;

  // Miss freezes win over everything; a pending flush owns the ID slot, so
  // hazards and new branches only matter once it has drained.
  always_comb begin
    is_branch = branch | branchr;
    needed    = FLAG_W'(cond_flag_mask(condition));
    l2u       = id_ex_mem_read && (id_ex_rd != '0) &&
                ((id_ex_rd == if_id_rs) || ((id_ex_rd == if_id_rt) && !if_id_mem_write));
    br_rs     = is_branch &&
                ((id_ex_reg_write && (id_ex_rd != '0) && (id_ex_rd == if_id_rs)) ||
                 (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == if_id_rs)));
    br_flag   = is_branch && ((needed & (id_ex_flag_en | ex_mem_flag_en)) != '0);
    haz       = l2u | br_rs | br_flag;

    any_miss  = dcache_miss | icache_miss;
    flushing  = !any_miss && (flush_rem != 3'd0);
    haz_stall = !any_miss && !flushing && haz;
    take      = !any_miss && !flushing && !haz && br_taken && is_branch;

    pc_wen       = !(any_miss | haz_stall);
    if_id_wen    = !(any_miss | haz_stall);
    id_ex_wen    = !dcache_miss;
    ex_mem_wen   = !dcache_miss;
    id_ex_bubble = !dcache_miss && (icache_miss || haz_stall);
    if_id_flush  = flushing | take;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_rem <= 3'd0;
    end else begin
      if (flushing) begin
        flush_rem <= flush_rem - 3'd1;
      end else if (take) begin
        flush_rem <= FLUSH_LOAD;
      end

      if (dcache_miss) begin
        state <= ST_DMISS;
      end else if (icache_miss) begin
        state <= ST_IMISS;
      end else if ((flushing && (flush_rem != 3'd1)) || (take && (FLUSH_LOAD != 3'd0))) begin
        state <= ST_FLUSH;
      end else begin
        state <= ST_RUN;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (any_miss | haz_stall),
    .clear (rst),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .inc   (if_id_flush),
    .clear (rst),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two configurations driven in lockstep and
// checked every cycle against a rule-level model, plus literal spot checks.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_ex_mem_read, id_ex_reg_write, ex_mem_reg_write, if_id_mem_write;
  logic [3:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
  logic       branch, branchr, br_taken, icache_miss, dcache_miss;
  logic [2:0] condition, id_ex_flag_en, ex_mem_flag_en;

  logic        pc0, ifid0, idex0, exmem0, bub0, fl0;
  logic        pc1, ifid1, idex1, exmem1, bub1, fl1;
  logic [3:0]  sc0, fc0;
  logic [15:0] sc1, fc1;
  logic [1:0]  st0, st1;

  // ctl packs {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, id_ex_bubble, if_id_flush}
  logic [5:0]  ctl [2];
  logic [1:0]  st [2];
  logic [15:0] scnt [2];
  logic [15:0] fcnt [2];

  assign ctl[0]  = {pc0, ifid0, idex0, exmem0, bub0, fl0};
  assign ctl[1]  = {pc1, ifid1, idex1, exmem1, bub1, fl1};
  assign st[0]   = st0;
  assign st[1]   = st1;
  assign scnt[0] = {12'd0, sc0};
  assign scnt[1] = sc1;
  assign fcnt[0] = {12'd0, fc0};
  assign fcnt[1] = fc1;

  hazard_ctrl_unit #(.REG_W(4), .FLAG_W(3), .FLUSH_CYCLES(3), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
    .ex_mem_reg_write(ex_mem_reg_write), .if_id_mem_write(if_id_mem_write),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd),
    .branch(branch), .branchr(branchr), .condition(condition),
    .id_ex_flag_en(id_ex_flag_en), .ex_mem_flag_en(ex_mem_flag_en), .br_taken(br_taken),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .pc_wen(pc0), .if_id_wen(ifid0), .id_ex_wen(idex0), .ex_mem_wen(exmem0),
    .id_ex_bubble(bub0), .if_id_flush(fl0), .stall_cnt(sc0), .flush_cnt(fc0), .state(st0)
  );

  hazard_ctrl_unit dut1 (
    .clk(clk), .rst(rst), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
    .ex_mem_reg_write(ex_mem_reg_write), .if_id_mem_write(if_id_mem_write),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd),
    .branch(branch), .branchr(branchr), .condition(condition),
    .id_ex_flag_en(id_ex_flag_en), .ex_mem_flag_en(ex_mem_flag_en), .br_taken(br_taken),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .pc_wen(pc1), .if_id_wen(ifid1), .id_ex_wen(idex1), .ex_mem_wen(exmem1),
    .id_ex_bubble(bub1), .if_id_flush(fl1), .stall_cnt(sc1), .flush_cnt(fc1), .state(st1)
  );

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    id_ex_mem_read = 0; id_ex_reg_write = 0; ex_mem_reg_write = 0; if_id_mem_write = 0;
    if_id_rs = 0; if_id_rt = 0; id_ex_rd = 0; ex_mem_rd = 0;
    branch = 0; branchr = 0; br_taken = 0; icache_miss = 0; dcache_miss = 0;
    condition = 0; id_ex_flag_en = 0; ex_mem_flag_en = 0;
  endtask

  task automatic doReset();
    setIdle();
    rst = 1;
    applyStimulus(1);
    rst = 0;
  endtask

  // Rule-level model: flags needed per condition code, owed flush cycles,
  // and counters clamped at their configured maximum.
  logic [2:0] need_tab [8] = '{3'b100, 3'b100, 3'b101, 3'b001, 3'b101, 3'b101, 3'b010, 3'b000};
  int flush_len [2] = '{3, 1};
  int cnt_max   [2] = '{15, 65535};
  int m_pend [2]  = '{0, 0};
  int m_state [2] = '{0, 0};
  int m_stall [2] = '{0, 0};
  int m_flush [2] = '{0, 0};

  initial begin
    int n_pend [2];
    int n_state [2];
    int n_stall [2];
    int n_flush [2];
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int i = 0; i < 2; i++) begin
          bit is_br, l2u, br_rs, br_flag, haz, stall_ev;
          logic [5:0] ectl;
          int pend, nst;
          is_br   = branch || branchr;
          l2u     = id_ex_mem_read && id_ex_rd != 0 &&
                    (id_ex_rd == if_id_rs || (id_ex_rd == if_id_rt && !if_id_mem_write));
          br_rs   = is_br && ((id_ex_reg_write && id_ex_rd != 0 && id_ex_rd == if_id_rs) ||
                              (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == if_id_rs));
          br_flag = is_br && ((need_tab[condition] & (id_ex_flag_en | ex_mem_flag_en)) != 0);
          haz     = l2u || br_rs || br_flag;
          pend    = m_pend[i];
          stall_ev = 0;
          if (dcache_miss) begin
            ectl = 6'b000000; stall_ev = 1; nst = 1;
          end else if (icache_miss) begin
            ectl = 6'b001110; stall_ev = 1; nst = 2;
          end else if (pend > 0) begin
            ectl = 6'b111101; pend = pend - 1; nst = (pend > 0) ? 3 : 0;
          end else if (haz) begin
            ectl = 6'b001110; stall_ev = 1; nst = 0;
          end else if (br_taken && is_br) begin
            ectl = 6'b111101; pend = flush_len[i] - 1; nst = (pend > 0) ? 3 : 0;
          end else begin
            ectl = 6'b111100; nst = 0;
          end
          checkOutput($sformatf("ctl_dut%0d", i), ctl[i], ectl);
          checkOutput($sformatf("state_dut%0d", i), st[i], m_state[i]);
          checkOutput($sformatf("stall_cnt_dut%0d", i), scnt[i], m_stall[i]);
          checkOutput($sformatf("flush_cnt_dut%0d", i), fcnt[i], m_flush[i]);
          if (rst) begin
            n_pend[i] = 0; n_state[i] = 0; n_stall[i] = 0; n_flush[i] = 0;
          end else begin
            n_pend[i]  = pend;
            n_state[i] = nst;
            n_stall[i] = (stall_ev && m_stall[i] < cnt_max[i]) ? m_stall[i] + 1 : m_stall[i];
            n_flush[i] = (ectl[0] && m_flush[i] < cnt_max[i]) ? m_flush[i] + 1 : m_flush[i];
          end
        end
      end
      @(posedge clk);
      if (checking) begin
        m_pend = n_pend; m_state = n_state; m_stall = n_stall; m_flush = n_flush;
      end
    end
  end

  typedef struct {
    logic       ex_wr;
    logic [3:0] ex_rd;
    logic       mem_wr;
    logic [3:0] mem_rd;
    logic       mem_read;
    logic [3:0] rs;
    logic       stall;
  } vec_t;

  vec_t tab [5] = '{
    '{1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1},
    '{1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 4'd5, 1'b1},
    '{1'b0, 4'd5, 1'b0, 4'd5, 1'b0, 4'd5, 1'b0},
    '{1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0},
    '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0}
  };

  initial begin
    setIdle();
    rst = 1;
    applyStimulus(2);
    checking = 1;
    applyStimulus(1);
    rst = 0;
    applyStimulus(1);
    checkOutput("reset_state", st[1], 0);
    checkOutput("reset_ctl", ctl[1], 6'b111100);
    checkOutput("reset_stall_cnt", scnt[1], 0);

    // load-to-use on rs stalls; rt match on a store does not
    id_ex_mem_read = 1; id_ex_rd = 3; if_id_rs = 3;
    #1 checkOutput("l2u_rs_ctl", ctl[1], 6'b001110);
    applyStimulus(1);
    if_id_rs = 0; if_id_rt = 3; if_id_mem_write = 1;
    #1 checkOutput("l2u_store_ctl", ctl[1], 6'b111100);
    checkOutput("l2u_stall_cnt", scnt[1], 1);
    applyStimulus(1);
    setIdle();

    // branch flag dependencies
    branch = 1; id_ex_flag_en = 3'b100; condition = 3'b000;
    #1 checkOutput("flag_eq_bubble", ctl[1][1], 1);
    applyStimulus(1);
    condition = 3'b110;
    #1 checkOutput("flag_ov_bubble", ctl[1][1], 0);
    applyStimulus(1);
    condition = 3'b111; id_ex_flag_en = 3'b111; ex_mem_flag_en = 3'b111;
    #1 checkOutput("flag_un_bubble", ctl[1][1], 0);
    applyStimulus(1);
    setIdle(); condition = 3'b011; branch = 1; ex_mem_flag_en = 3'b001;
    #1 checkOutput("flag_lt_bubble", ctl[1][1], 1);
    applyStimulus(1);

    // taken branch, held for three cycles; dut0 ignores the repeats while flushing
    doReset();
    branch = 1; br_taken = 1;
    applyStimulus(1);
    checkOutput("flush_state_1", st[0], 3);
    applyStimulus(1);
    checkOutput("flush_state_2", st[0], 3);
    applyStimulus(1);
    checkOutput("flush_state_3", st[0], 0);
    checkOutput("flush_cnt_fc3", fcnt[0], 3);
    checkOutput("flush_cnt_fc1", fcnt[1], 3);
    setIdle();
    applyStimulus(1);

    // dcache miss preempts a flush, which resumes afterwards
    doReset();
    branch = 1; br_taken = 1;
    applyStimulus(1);
    setIdle(); dcache_miss = 1;
    applyStimulus(2);
    checkOutput("preempt_state", st[0], 1);
    dcache_miss = 0;
    applyStimulus(2);
    checkOutput("resume_state", st[0], 0);
    checkOutput("resume_flush_cnt", fcnt[0], 3);
    checkOutput("resume_flush_cnt_fc1", fcnt[1], 1);

    // dcache > icache > load-use priority
    doReset();
    icache_miss = 1; dcache_miss = 1; id_ex_mem_read = 1; id_ex_rd = 3; if_id_rs = 3;
    applyStimulus(1);
    checkOutput("dmiss_state", st[1], 1);
    applyStimulus(3);
    dcache_miss = 0;
    #1 checkOutput("imiss_ctl", ctl[1], 6'b001110);
    applyStimulus(2);
    checkOutput("imiss_state", st[1], 2);
    icache_miss = 0;
    applyStimulus(1);
    checkOutput("miss_run_state", st[1], 0);
    checkOutput("miss_stall_cnt", scnt[1], 7);

    // saturation, then reset in the middle of a flush
    doReset();
    id_ex_mem_read = 1; id_ex_rd = 3; if_id_rs = 3;
    applyStimulus(20);
    checkOutput("sat_stall_cnt4", scnt[0], 15);
    checkOutput("sat_stall_cnt16", scnt[1], 20);
    setIdle(); branch = 1; br_taken = 1;
    applyStimulus(1);
    setIdle();
    checkOutput("pre_rst_state", st[0], 3);
    rst = 1;
    applyStimulus(1);
    rst = 0;
    checkOutput("rst_state", st[0], 0);
    checkOutput("rst_stall_cnt", scnt[0], 0);
    checkOutput("rst_flush_cnt", fcnt[0], 0);
    #1 checkOutput("rst_if_id_flush", ctl[0][0], 0);
    applyStimulus(1);

    // branch-register RAW and zero-register cases, each with br_taken raised
    foreach (tab[k]) begin
      setIdle();
      branchr = 1; br_taken = 1;
      id_ex_reg_write = tab[k].ex_wr; id_ex_rd = tab[k].ex_rd;
      ex_mem_reg_write = tab[k].mem_wr; ex_mem_rd = tab[k].mem_rd;
      id_ex_mem_read = tab[k].mem_read; if_id_rs = tab[k].rs;
      #1 checkOutput($sformatf("brr_bubble_%0d", k), ctl[1][1], tab[k].stall);
      checkOutput($sformatf("brr_flush_%0d", k), ctl[1][0], !tab[k].stall);
      applyStimulus(1);
      setIdle();
      applyStimulus(3);
    end

    applyStimulus(2);
    checking = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
